// File: rtl/keypad_entry.sv
// -----------------------------------------------------------------------------
// keypad_entry
//
// Turns raw key presses from a 20-to-5 key encoder into a multi-digit BCD
// entry. The encoder outputs are asynchronous to clk, so they pass through a
// two-flop synchronizer. A third strobe flop provides rising-edge detection,
// which makes each physical press produce exactly one event.
//
// Key map: 0-9 digit, 16 ENTER, 17 BACKSPACE, 18 CLEAR, others invalid.
//
// Ports
//   clk     in   system clock, rising edge
//   nrst    in   asynchronous active-low reset
//   code    in   [4:0] encoder key index (asynchronous)
//   strobe  in   encoder "any key pressed" (asynchronous)
//   value   out  [4*DIGITS-1:0] entered BCD digits, newest digit in [3:0]
//   count   out  number of valid digits held (0..DIGITS)
//   press   out  one-cycle pulse per detected key event
//   err     out  one-cycle pulse on a rejected key
//   done    out  high while a completed entry is presented
// -----------------------------------------------------------------------------
module keypad_entry #(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [4:0]                   code,
    input  logic                         strobe,
    output logic [4*DIGITS-1:0]          value,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         press,
    output logic                         err,
    output logic                         done
);

    localparam int VW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(DIGITS);
    localparam logic [CW-1:0] ONE  = CW'(1);

    localparam logic [4:0] KEY_ENTER = 5'd16;
    localparam logic [4:0] KEY_BKSP  = 5'd17;
    localparam logic [4:0] KEY_CLEAR = 5'd18;

    typedef enum logic [0:0] {
        S_ENTRY = 1'b0,
        S_DONE  = 1'b1
    } state_t;

    // Synchronizer and edge-detect flops
    logic [4:0] code_s1_q, code_s2_q;
    logic       strobe_s1_q, strobe_s2_q, strobe_s3_q;

    // Entry state and registered outputs
    state_t         state_q, state_d;
    logic [VW-1:0]  value_q, value_d;
    logic [CW-1:0]  count_q, count_d;
    logic           press_q, press_d;
    logic           err_q, err_d;
    logic           done_q, done_d;

    logic       press_event;
    logic [4:0] key;
    logic       is_digit;
    logic       is_enter;
    logic       is_bksp;
    logic       is_clear;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            code_s1_q   <= '0;
            code_s2_q   <= '0;
            strobe_s1_q <= 1'b0;
            strobe_s2_q <= 1'b0;
            strobe_s3_q <= 1'b0;
        end else begin
            code_s1_q   <= code;
            code_s2_q   <= code_s1_q;
            strobe_s1_q <= strobe;
            strobe_s2_q <= strobe_s1_q;
            strobe_s3_q <= strobe_s2_q;
        end
    end

    // Only the rising edge of the synchronized strobe counts, so a held key,
    // or a code change while the strobe stays high, yields no new event.
    assign press_event = strobe_s2_q & ~strobe_s3_q;
    assign key         = code_s2_q;
    assign is_digit    = (key <= 5'd9);
    assign is_enter    = (key == KEY_ENTER);
    assign is_bksp     = (key == KEY_BKSP);
    assign is_clear    = (key == KEY_CLEAR);

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        count_d = count_q;
        press_d = press_event;
        err_d   = 1'b0;

        if (press_event) begin
            if (!(is_digit || is_enter || is_bksp || is_clear)) begin
                // Invalid key: flag it and leave everything else alone
                err_d = 1'b1;
            end else begin
                unique case (state_q)
                    S_ENTRY: begin
                        if (is_digit) begin
                            if (count_q < FULL) begin
                                // Left shift drops nothing useful; for DIGITS=1
                                // the shifted term is zero and this is a load.
                                value_d = (value_q << 4) | VW'(key[3:0]);
                                count_d = count_q + ONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (is_enter) begin
                            if (count_q != '0) begin
                                state_d = S_DONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (is_bksp) begin
                            if (count_q != '0) begin
                                value_d = value_q >> 4;
                                count_d = count_q - ONE;
                            end
                        end else begin
                            value_d = '0;
                            count_d = '0;
                        end
                    end
                    S_DONE: begin
                        if (is_digit) begin
                            // A digit after ENTER starts a fresh entry
                            value_d = VW'(key[3:0]);
                            count_d = ONE;
                            state_d = S_ENTRY;
                        end else if (is_clear) begin
                            value_d = '0;
                            count_d = '0;
                            state_d = S_ENTRY;
                        end else if (is_bksp) begin
                            // Resume editing the presented value
                            state_d = S_ENTRY;
                            if (count_q != '0) begin
                                value_d = value_q >> 4;
                                count_d = count_q - ONE;
                            end
                        end
                        // ENTER while done is a no-op
                    end
                    default: begin
                        state_d = S_ENTRY;
                    end
                endcase
            end
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_ENTRY;
            value_q <= '0;
            count_q <= '0;
            press_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            count_q <= count_d;
            press_q <= press_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign value = value_q;
    assign count = count_q;
    assign press = press_q;
    assign err   = err_q;
    assign done  = done_q;

endmodule

// File: tb/tb_keypad_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_entry
//
// Directed bench for keypad_entry with DIGITS=4. Keys are driven as strobe
// pulses starting at a falling clock edge; outputs are sampled 1 time unit
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_keypad_entry;

    logic        clk;
    logic        nrst;
    logic [4:0]  code;
    logic        strobe;
    logic [15:0] value;
    logic [2:0]  count;
    logic        press;
    logic        err;
    logic        done;

    int n_cmp;
    int n_bad;

    keypad_entry #(.DIGITS(4)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .code   (code),
        .strobe (strobe),
        .value  (value),
        .count  (count),
        .press  (press),
        .err    (err),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one key: strobe high for 'hold' rising edges, then low long
    // enough to flush the synchronizer. Reports press/err pulse counts and
    // the 1-based edge index at which press was first seen.
    task automatic send_key(input logic [4:0] c, input int hold,
                            output int np, output int ne, output int first);
        np = 0;
        ne = 0;
        first = 0;
        @(negedge clk);
        code   = c;
        strobe = 1'b1;
        for (int i = 1; i <= hold + 6; i++) begin
            @(posedge clk);
            #1;
            if (press) begin
                np++;
                if (first == 0) first = i;
            end
            if (err) ne++;
            if (i == hold) strobe = 1'b0;
        end
    endtask

    task automatic key(input string tag, input logic [4:0] c, input int exp_err);
        int np, ne, first;
        send_key(c, 5, np, ne, first);
        chk({tag, "_press"}, np, 1);
        chk({tag, "_err"}, ne, exp_err);
    endtask

    initial begin
        int np, ne, first;
        n_cmp  = 0;
        n_bad  = 0;
        code   = 5'd0;
        strobe = 1'b0;
        nrst   = 1'b1;
        #1 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value, 16'h0000);
        chk("rst_count", count, 0);
        chk("rst_press", press, 0);
        chk("rst_err",   err,   0);
        chk("rst_done",  done,  0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(posedge clk);

        // Digits 1,2,3; first press must appear at E2 (third sampled edge)
        send_key(5'd1, 5, np, ne, first);
        chk("k1_press", np, 1);
        chk("k1_lat",   first, 3);
        chk("k1_err",   ne, 0);
        key("k2", 5'd2, 0);
        key("k3", 5'd3, 0);
        chk("v0123", value, 16'h0123);
        chk("c3",    count, 3);

        // Fill to capacity, then overflow is rejected
        key("clr1", 5'd18, 0);
        chk("clr1_v", value, 16'h0000);
        chk("clr1_c", count, 0);
        key("k4", 5'd4, 0);
        key("k5", 5'd5, 0);
        key("k6", 5'd6, 0);
        key("k7", 5'd7, 0);
        chk("v4567", value, 16'h4567);
        chk("c4",    count, 4);
        key("k8_full", 5'd8, 1);
        chk("full_v", value, 16'h4567);
        chk("full_c", count, 4);

        // Backspace, enter, then a digit restarts the entry
        key("bs1", 5'd17, 0);
        chk("bs1_v", value, 16'h0456);
        chk("bs1_c", count, 3);
        key("ent1", 5'd16, 0);
        chk("ent1_done", done, 1);
        chk("ent1_v", value, 16'h0456);
        key("k9", 5'd9, 0);
        chk("k9_v",    value, 16'h0009);
        chk("k9_c",    count, 1);
        chk("k9_done", done, 0);

        // Rejections and no-ops
        key("clr2", 5'd18, 0);
        key("ent_empty", 5'd16, 1);
        chk("ent_empty_done", done, 0);
        key("k5b", 5'd5, 0);
        key("inv12", 5'd12, 1);
        chk("inv12_v", value, 16'h0005);
        chk("inv12_c", count, 1);
        key("inv19", 5'd19, 1);
        chk("inv19_v", value, 16'h0005);

        // DONE-state handling: ENTER no-op, BACKSPACE resumes and applies
        key("ent2", 5'd16, 0);
        chk("ent2_done", done, 1);
        key("ent3", 5'd16, 0);
        chk("ent3_done", done, 1);
        chk("ent3_v", value, 16'h0005);
        key("bs_done", 5'd17, 0);
        chk("bs_done_done", done, 0);
        chk("bs_done_v", value, 16'h0000);
        chk("bs_done_c", count, 0);
        key("bs_empty", 5'd17, 0);
        chk("bs_empty_c", count, 0);

        // Held strobe with code changing 3 -> 5: a single event with digit 3
        np = 0;
        ne = 0;
        @(negedge clk);
        code   = 5'd3;
        strobe = 1'b1;
        for (int i = 1; i <= 56; i++) begin
            @(posedge clk);
            #1;
            if (press) np++;
            if (err) ne++;
            if (i == 20) code = 5'd5;
            if (i == 50) strobe = 1'b0;
        end
        chk("hold_press", np, 1);
        chk("hold_err",   ne, 0);
        chk("hold_v",     value, 16'h0003);
        chk("hold_c",     count, 1);

        // Asynchronous reset mid-entry clears outputs before the next edge
        key("clr3", 5'd18, 0);
        key("r1", 5'd1, 0);
        key("r2", 5'd2, 0);
        chk("pre_rst_v", value, 16'h0012);
        chk("pre_rst_c", count, 2);
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("arst_v",    value, 16'h0000);
        chk("arst_c",    count, 0);
        chk("arst_done", done,  0);
        chk("arst_err",  err,   0);
        @(negedge clk);
        nrst = 1'b1;
        key("k7_post", 5'd7, 0);
        chk("post_v", value, 16'h0007);
        chk("post_c", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Backstop so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
